fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline in top_cpu.
- Issues in-order word fetches to instruction memory over a req/ready + rvalid handshake, buffers returned words in a small FIFO, and drives the IF/ID pipeline register consumed by decode.
- Takes stall from the hazard unit (load-use bubble) and redirect from branch/jump resolution; on redirect it flushes the FIFO and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset.
- FIFO_DEPTH, 2, fetch buffer entries (power of 2, >=2).
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered imem requests (<=FIFO_DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- stall  in  1  hazard unit: hold IF/ID contents, no FIFO pop.
- redirect  in  1  branch taken / jump from EX: flush and refetch.
- redirect_pc  in  32  redirect target; bits [1:0] forced to 0.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch word address (byte address, [1:0]=0).
- imem_ready  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  response valid, strictly in request order.
- imem_rdata  in  32  instruction word.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_instr  out  32  instruction (32'h0 = NOP when invalid).
- if_id_pc4  out  32  address of instruction + 4.

Behaviour:
- Reset (async, reset=0): fetch_pc=RESET_PC, outstanding=0, drop_cnt=0, FIFO empty, if_id_valid=0, if_id_instr=0, if_id_pc4=0, imem_req=0. The first request is issued in the first cycle after reset deasserts.
- imem_req = !redirect && (outstanding + fifo_count < FIFO_DEPTH) && (outstanding < MAX_OUTSTANDING).
- imem_addr = fetch_pc.
- Accept: imem_req && imem_ready. Then fetch_pc += 4 (wraps mod 2^32; 32'hFFFFFFFC -> 0) and outstanding += 1.
- Response: imem_rvalid. Outstanding -= 1.
  - If drop_cnt > 0: discard the word and decrement drop_cnt.
  - Otherwise: push {imem_rdata, pc+4} into the FIFO. The per-request pc is tracked in a MAX_OUTSTANDING-deep tag queue.
- Accept and response in the same cycle: outstanding is unchanged.
- IF/ID update, priority order:
  1. redirect: if_id_valid=0, if_id_instr=0.
  2. stall: hold all IF/ID outputs.
  3. FIFO non-empty: pop head into IF/ID, valid=1.
  4. FIFO empty: bubble, valid=0, instr=0, pc4 held.
- Redirect cycle:
  - FIFO cleared.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - drop_cnt <= outstanding, counted after this cycle's response. A response arriving in the redirect cycle is itself discarded.
  - No request is issued in the redirect cycle.
  - Redirect overrides a simultaneous stall.
- Latency: with a 1-cycle memory, no stall and no redirect, the instruction at address A appears in IF/ID 2 cycles after its request is accepted. Steady-state throughput is 1 instruction/cycle.
- FIFO full: no push can occur, because the credit rule guarantees space. A response arriving with the FIFO full is a protocol violation (assertion).
- Reset mid-operation clears all state. Responses for pre-reset requests are not expected; the memory is reset together with the stage.

Optional Feature:
- IF_PERF_CNT_EN defined:
  - Adds output bubble_cnt (32).
  - Increments, saturating at 32'hFFFFFFFF, on each cycle where IF/ID loads a bubble because the FIFO is empty, with no redirect and no stall.
  - Reset value 0.
- Undefined: the port and counter are absent.

Decomposition:
- cpu_pkg holds:
  - NOP_INSTR (32'h0).
  - WORD_W (32).
  - PC_INC (4).
  - RESET_PC default.
  - typedef fetch_entry_t {instr[31:0], pc4[31:0]}.
- One sub-module, fetch_fifo: a parameterised synchronous FIFO of fetch_entry_t with a flush input, push/pop, and count, full and empty outputs.
- The tag queue reuses fetch_fifo.

Test Plan:
- Reset release, 1-cycle memory returning word = address: IF/ID sequence pc4 = 4, 8, 12, ... with instr = 0, 4, 8; imem_req high every cycle.
- Stall held 3 cycles mid-stream: if_id_instr frozen at the same value for 3 cycles; FIFO fills to 2; imem_req drops; no instruction lost or duplicated after release.
- Redirect to 32'h00000043 with 2 requests outstanding: both stale responses discarded; next valid IF/ID has pc4 = 32'h44, instr from 32'h40.
- Redirect and stall asserted together: if_id_valid = 0 next cycle; fetch resumes at the target.
- Memory with imem_ready low 5 cycles, then rvalid with 3-cycle latency: outstanding never exceeds 2; bubbles with instr = 0; order preserved.
- fetch_pc at 32'hFFFFFFFC: next imem_addr = 0; if_id_pc4 = 0 for that instruction. With IF_PERF_CNT_EN, bubble_cnt equals the number of empty-FIFO bubbles counted.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and the fetch buffer entry type for the top_cpu pipeline.
package cpu_pkg;

    localparam int unsigned       WORD_W           = 32;
    localparam logic [WORD_W-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [WORD_W-1:0] PC_INC           = 32'd4;
    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t with flush; head is readable combinationally.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     pop_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: credit-limited imem fetch, response buffer and IF/ID register.
// Optional IF_PERF_CNT_EN adds a saturating empty-buffer bubble counter.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] bubble_cnt
`endif
);

    localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);

    logic              running_q;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [OUT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic              if_id_valid_q, if_id_valid_d;
    logic [31:0]       if_id_instr_q, if_id_instr_d;
    logic [31:0]       if_id_pc4_q, if_id_pc4_d;

    logic              accept, bypass;
    logic              tag_push, tag_pop, tag_empty, tag_full;
    logic              data_push, data_pop, data_empty, data_full;
    logic [OUT_W-1:0]  outstanding;
    logic [FCNT_W-1:0] fifo_count;
    fetch_entry_t      tag_in, tag_head, data_in, data_head;
    logic              unused_bits;

    assign imem_req  = running_q && !redirect
                     && (32'(outstanding) + 32'(fifo_count) < FIFO_DEPTH)
                     && (32'(outstanding) < MAX_OUTSTANDING);
    assign imem_addr = fetch_pc_q;
    assign accept    = imem_req && imem_ready;

    // A response with no queued tag belongs to the request accepted this same cycle.
    assign bypass    = imem_rvalid && tag_empty;
    assign tag_push  = accept && !bypass;
    assign tag_pop   = imem_rvalid && !tag_empty;
    assign tag_in    = '{instr: fetch_pc_q, pc4: fetch_pc_q + PC_INC};

    assign data_push = imem_rvalid && !redirect && (drop_cnt_q == '0);
    assign data_pop  = !redirect && !stall && !data_empty;
    assign data_in   = '{instr: imem_rdata, pc4: bypass ? fetch_pc_q + PC_INC : tag_head.pc4};

    fetch_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (1'b0),
        .push      (tag_push),
        .push_data (tag_in),
        .pop       (tag_pop),
        .pop_data  (tag_head),
        .count     (outstanding),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_data_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (data_push),
        .push_data (data_in),
        .pop       (data_pop),
        .pop_data  (data_head),
        .count     (fifo_count),
        .full      (data_full),
        .empty     (data_empty)
    );

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        drop_cnt_d    = drop_cnt_q;
        if_id_valid_d = if_id_valid_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc4_d   = if_id_pc4_q;

        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            // Everything still in flight after this cycle's response is stale.
            drop_cnt_d = outstanding - OUT_W'(imem_rvalid);
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + PC_INC;
            if (imem_rvalid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
        end

        if (redirect) begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
        end else if (!stall) begin
            if (!data_empty) begin
                if_id_valid_d = 1'b1;
                if_id_instr_d = data_head.instr;
                if_id_pc4_d   = data_head.pc4;
            end else begin
                if_id_valid_d = 1'b0;
                if_id_instr_d = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            running_q     <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            drop_cnt_q    <= '0;
            if_id_valid_q <= 1'b0;
            if_id_instr_q <= NOP_INSTR;
            if_id_pc4_q   <= '0;
        end else begin
            running_q     <= 1'b1;
            fetch_pc_q    <= fetch_pc_d;
            drop_cnt_q    <= drop_cnt_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc4_q   <= if_id_pc4_d;
        end
    end

    assign if_id_valid = if_id_valid_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc4   = if_id_pc4_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!redirect && !stall && data_empty && (bubble_cnt_q != '1))
            bubble_cnt_d = bubble_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) bubble_cnt_q <= '0;
        else        bubble_cnt_q <= bubble_cnt_d;
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

    assign unused_bits = ^{tag_head.instr, redirect_pc[1:0], tag_full, data_full};

    a_rvalid_has_request: assert property (@(posedge clk) disable iff (!reset)
        imem_rvalid |-> (!tag_empty || accept));
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset)
        data_push |-> (!data_full || data_pop));

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage with a configurable-latency memory model.
`timescale 1ns/1ps
module tb_fetch_stage;
    import cpu_pkg::*;

    localparam int          DEPTH = 2;
    localparam int          MAXO  = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
`ifdef IF_PERF_CNT_EN
    logic [31:0] bubble_cnt;
`endif

    fetch_stage #(
        .RESET_PC        (RPC),
        .FIFO_DEPTH      (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_id_valid (if_id_valid),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4)
`ifdef IF_PERF_CNT_EN
        ,
        .bubble_cnt  (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: program-order words owed to IF/ID, memory pipeline, credit bookkeeping.
    fetch_entry_t exp_q[$];
    logic [31:0]  mem_addr_q[$];
    int           mem_due_q[$];
    logic [31:0]  model_pc = RPC;
    int           inflight = 0;
    int           stale = 0;
    int           max_inflight = 0;
    int           cycle = 0;
    int           lat = 0;
    int           bubbles = 0;
    bit           started = 1'b0;

    logic         last_valid = 1'b0;
    logic [31:0]  last_instr = '0;
    logic [31:0]  last_pc4 = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor_step();
        fetch_entry_t e;
        if (redirect) begin
            check("redirect_valid", 32'(if_id_valid), 32'd0);
            check("redirect_instr", if_id_instr, NOP_INSTR);
        end else if (stall) begin
            check("stall_hold_valid", 32'(if_id_valid), 32'(last_valid));
            check("stall_hold_instr", if_id_instr, last_instr);
            check("stall_hold_pc4", if_id_pc4, last_pc4);
        end else if (if_id_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_instr: got pc4 %h with nothing owed at %0t", if_id_pc4, $time);
            end else begin
                e = exp_q.pop_front();
                check("if_id_instr", if_id_instr, e.instr);
                check("if_id_pc4", if_id_pc4, e.pc4);
            end
        end else begin
            check("bubble_instr", if_id_instr, NOP_INSTR);
            check("bubble_pc4_hold", if_id_pc4, last_pc4);
            bubbles++;
        end
        last_valid = if_id_valid;
        last_instr = if_id_instr;
        last_pc4   = if_id_pc4;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) monitor_step();
        end
    end

    task automatic drive_cycle(input bit st, input bit rd, input logic [31:0] rpc, input bit rdy);
        bit           resp;
        bit           acc;
        bit           exp_req;
        fetch_entry_t e;
        @(posedge clk);
        #2;
        cycle++;
        resp        = 1'b0;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ready  = rdy;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (rd) begin
            exp_q.delete();
            stale    = inflight;
            model_pc = {rpc[31:2], 2'b00};
        end
        if (mem_addr_q.size() > 0 && mem_due_q[0] <= cycle) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_addr_q.pop_front();
            void'(mem_due_q.pop_front());
            resp = 1'b1;
        end
        #1;
        exp_req = started && !rd && (exp_q.size() + stale < DEPTH) && (inflight < MAXO);
        check("imem_req", 32'(imem_req), 32'(exp_req));
        acc = imem_req && rdy;
        if (acc) begin
            check("imem_addr", imem_addr, model_pc);
            if (lat == 0 && mem_addr_q.size() == 0 && !resp) begin
                imem_rvalid = 1'b1;
                imem_rdata  = imem_addr;
                resp        = 1'b1;
            end else begin
                mem_addr_q.push_back(imem_addr);
                mem_due_q.push_back(cycle + ((lat == 0) ? 1 : lat));
            end
        end
        if (resp) begin
            inflight--;
            if (stale > 0) stale--;
        end
        if (acc) begin
            inflight++;
            e.instr = model_pc;
            e.pc4   = model_pc + 32'd4;
            exp_q.push_back(e);
            model_pc = model_pc + 32'd4;
        end
        if (inflight > max_inflight) max_inflight = inflight;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        exp_q.delete();
        mem_addr_q.delete();
        mem_due_q.delete();
        inflight   = 0;
        stale      = 0;
        model_pc   = RPC;
        started    = 1'b0;
        bubbles    = 0;
        lat        = 0;
        last_valid = 1'b0;
        last_instr = '0;
        last_pc4   = '0;
        #1;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_if_id_valid", 32'(if_id_valid), 32'd0);
        check("rst_if_id_instr", if_id_instr, NOP_INSTR);
        check("rst_if_id_pc4", if_id_pc4, 32'd0);
`ifdef IF_PERF_CNT_EN
        check("rst_bubble_cnt", bubble_cnt, 32'd0);
`endif
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("req_in_release_cycle", 32'(imem_req), 32'd0);
        started = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || inflight != 0) && n < 40) begin
            drive_cycle(1'b0, 1'b0, 32'd0, 1'b0);
            n++;
        end
        check("drain_nothing_lost", 32'(exp_q.size()), 32'd0);
        check("drain_inflight", 32'(inflight), 32'd0);
    endtask

    initial begin
        int n;
        do_reset();

        // Single-cycle memory, continuous stream from RESET_PC.
        lat = 0;
        repeat (12) drive_cycle(1'b0, 1'b0, 32'd0, 1'b1);

        // Three-cycle stall mid-stream.
        repeat (3) drive_cycle(1'b1, 1'b0, 32'd0, 1'b1);
        repeat (8) drive_cycle(1'b0, 1'b0, 32'd0, 1'b1);

        // Build two outstanding requests, then redirect to an unaligned target.
        lat = 3;
        n = 0;
        while (inflight < 2 && n < 10) begin
            drive_cycle(1'b0, 1'b0, 32'd0, 1'b1);
            n++;
        end
        check("two_outstanding_before_redirect", 32'(inflight), 32'd2);
        drive_cycle(1'b0, 1'b1, 32'h0000_0043, 1'b1);
        repeat (12) drive_cycle(1'b0, 1'b0, 32'd0, 1'b1);

        // Redirect and stall together.
        drive_cycle(1'b1, 1'b1, 32'h0000_0100, 1'b1);
        repeat (10) drive_cycle(1'b0, 1'b0, 32'd0, 1'b1);

        // Memory not ready for five cycles, then three-cycle latency.
        repeat (5) drive_cycle(1'b0, 1'b0, 32'd0, 1'b0);
        repeat (20) drive_cycle(1'b0, 1'b0, 32'd0, 1'b1);

        // Address wrap past 32'hFFFFFFFC.
        lat = 0;
        drive_cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        repeat (10) drive_cycle(1'b0, 1'b0, 32'd0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 29) == 0) lat = $urandom_range(0, 3);
            drive_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                        $urandom, $urandom_range(0, 3) != 0);
        end
        drain();

        // Reset in the middle of activity, then restart from RESET_PC.
        lat = 2;
        for (int i = 0; i < 25; i++) begin
            drive_cycle($urandom_range(0, 3) == 0, 1'b0, 32'd0, 1'b1);
        end
        do_reset();
        repeat (15) drive_cycle(1'b0, 1'b0, 32'd0, 1'b1);
        drain();

        check("max_outstanding_within_limit", 32'(max_inflight <= MAXO), 32'd1);
`ifdef IF_PERF_CNT_EN
        check("bubble_cnt", bubble_cnt, 32'(bubbles));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
